// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

    // Instruction width follows the command-field width of the 16-bit PU.
    localparam int CMDS   = 15;
    localparam int AW_DEF = 16;
    localparam int IW_DEF = CMDS + 1;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    // Next-PC source selection.
    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_JUMP = 2'd2
    } pc_sel_t;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register with its next-PC mux (hold / increment / jump).
module fetch_unit_pc_reg
    import fetch_unit_pkg::*;
#(
    parameter int            AW       = AW_DEF,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  pc_sel_t       pc_sel,
    input  logic [AW-1:0] jt,
    output logic [AW-1:0] pc
);

    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d;

    // Next PC: increment wraps naturally modulo 2^AW.
    always_comb begin
        pc_d = pc_q;
        unique case (pc_sel)
            PC_INC:  pc_d = pc_q + 1'b1;
            PC_JUMP: pc_d = jt;
            default: pc_d = pc_q;
        endcase
    end

    // PC register, asynchronously reset to the boot address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequences memory requests, holds the instruction
// register for the decoder and chooses the next PC from decoder feedback.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int            AW       = AW_DEF,
    parameter int            IW       = IW_DEF,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_rdata,
    output logic [IW-1:0] inst,
    output logic          inst_vld,
    input  logic          h,
    input  logic          pcwe,
    input  logic [AW-1:0] jt,
    output logic [AW-1:0] pc,
    output logic          halted,
    output logic [15:0]   icnt
);

    fetch_state_t  state_q, state_d;
    logic [IW-1:0] inst_q,  inst_d;
    logic [15:0]   icnt_q,  icnt_d;
    pc_sel_t       pc_sel;

    fetch_unit_pc_reg #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .pc_sel (pc_sel),
        .jt     (jt),
        .pc     (pc)
    );

    // Next-state, instruction latch, retire count and PC selection.
    // Acks are only honoured in FETCH; run only in IDLE/HALT; decoder
    // feedback only in EXEC, where halt overrides a taken branch.
    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        icnt_d  = icnt_q;
        pc_sel  = PC_HOLD;
        unique case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    inst_d  = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                icnt_d = icnt_q + 16'd1;
                if (h) begin
                    state_d = ST_HALT;
                end else if (pcwe) begin
                    pc_sel  = PC_JUMP;
                    state_d = ST_FETCH;
                end else begin
                    pc_sel  = PC_INC;
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (run) begin
                    pc_sel  = PC_INC;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, instruction register and retire counter; reset aborts any fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            inst_q  <= '0;
            icnt_q  <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            icnt_q  <= icnt_d;
        end
    end

    // Outputs decode directly from registered state, so reset clears them at once.
    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc;
    assign inst_vld  = (state_q == ST_EXEC);
    assign halted    = (state_q == ST_HALT);
    assign inst      = inst_q;
    assign icnt      = icnt_q;

endmodule
